// File: rtl/nv_nvdla_cdma_img_pkg.sv
// nv_nvdla_cdma_img_pkg
//   Shared constants for the CDMA image-path FIFO write arbiter.
//   - IDW    : requester ID width carried in the FIFO upper bits
//   - FIFO_W : FIFO word width ({id, payload})
//   - OCW    : per-requester occupancy counter width
//   - BCW    : burst counter width
//   - ARB_IDLE / ARB_GRANT : arbiter FSM state encodings
package nv_nvdla_cdma_img_pkg;

   localparam int unsigned IDW    = 2;
   localparam int unsigned FIFO_W = 11;
   localparam int unsigned OCW    = 6;
   localparam int unsigned BCW    = 3;

   typedef logic [0:0] arb_state_t;

   localparam arb_state_t ARB_IDLE  = 1'b0;
   localparam arb_state_t ARB_GRANT = 1'b1;

endpackage

// File: rtl/nv_nvdla_cdma_img_rr_pick.sv
// nv_nvdla_cdma_img_rr_pick
//   Combinational NREQ-way round-robin first-one finder.
//   Scans elig starting at rr_ptr, then rr_ptr+1, ... (mod NREQ).
//   Ports:
//     elig   in  NREQ  eligible requesters
//     rr_ptr in  IDW   scan start index
//     found  out 1     at least one requester eligible
//     idx    out IDW   first eligible index in scan order
module nv_nvdla_cdma_img_rr_pick
   import nv_nvdla_cdma_img_pkg::*;
#(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0] elig,
   input  logic [IDW-1:0]  rr_ptr,
   output logic            found,
   output logic [IDW-1:0]  idx
);

   logic [IDW-1:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = IDW'((32'(rr_ptr) + k) % NREQ);
         if (!found && elig[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/nv_nvdla_cdma_img_fifo_arb.sv
// nv_nvdla_cdma_img_fifo_arb
//   Round-robin arbiter sharing the image-path FIFO write port between
//   NREQ requesters, with per-requester occupancy quota tracked by
//   snooping FIFO pops.
//   Ports:
//     clk, reset             clock, asynchronous active-high reset
//     req_valid/data/last    per-requester beat (data i at [i*DW +: DW])
//     req_ready              per-requester accept
//     fifo_wr_req/data       FIFO write port, data = {id, payload}
//     fifo_wr_ready          FIFO write accept
//     fifo_rd_req/ready/id   snoop of FIFO pops and popped entry ID
//     occ                    per-requester occupancy (OCW bits each)
//     idle                   arbiter idle and FIFO holds none of our beats
module nv_nvdla_cdma_img_fifo_arb
   import nv_nvdla_cdma_img_pkg::*;
#(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned DW        = 9,
   parameter int unsigned QUOTA     = 32,
   parameter int unsigned MAX_BURST = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ*DW-1:0]  req_data,
   input  logic [NREQ-1:0]     req_last,
   output logic [NREQ-1:0]     req_ready,
   output logic                fifo_wr_req,
   output logic [FIFO_W-1:0]   fifo_wr_data,
   input  logic                fifo_wr_ready,
   input  logic                fifo_rd_req,
   input  logic                fifo_rd_ready,
   input  logic [IDW-1:0]      fifo_rd_id,
   output logic [NREQ*OCW-1:0] occ,
   output logic                idle
);

   localparam logic [OCW-1:0] QUOTA_C   = OCW'(QUOTA);
   localparam logic [BCW-1:0] BCNT_LAST = BCW'(MAX_BURST - 1);

   arb_state_t                 state_q, state_d;
   logic [IDW-1:0]             gnt_q, gnt_d;
   logic [IDW-1:0]             rr_ptr_q, rr_ptr_d;
   logic [BCW-1:0]             bcnt_q, bcnt_d;
   logic [NREQ-1:0][OCW-1:0]   occ_q, occ_d;

   logic [DW-1:0]   req_pl [NREQ];
   logic [NREQ-1:0] elig;
   logic            pick_found;
   logic [IDW-1:0]  pick_idx;
   logic            xfer;
   logic            pop;
   logic            inc;
   logic            dec;

   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         req_pl[i] = req_data[i*DW +: DW];
         elig[i]   = req_valid[i] && (occ_q[i] < QUOTA_C);
      end
   end

   nv_nvdla_cdma_img_rr_pick #(
      .NREQ (NREQ)
   ) u_rr_pick (
      .elig   (elig),
      .rr_ptr (rr_ptr_q),
      .found  (pick_found),
      .idx    (pick_idx)
   );

   // Write-port outputs depend only on registered state and requester
   // inputs, so fifo_wr_ready never reaches fifo_wr_req.
   always_comb begin
      fifo_wr_req  = 1'b0;
      fifo_wr_data = '0;
      req_ready    = '0;
      if (state_q == ARB_GRANT) begin
         fifo_wr_req        = elig[gnt_q];
         fifo_wr_data       = FIFO_W'({gnt_q, req_pl[gnt_q]});
         req_ready[gnt_q]   = fifo_wr_ready && (occ_q[gnt_q] < QUOTA_C);
      end
      xfer = fifo_wr_req && fifo_wr_ready;
      pop  = fifo_rd_req && fifo_rd_ready;
   end

   // Occupancy: a same-cycle write and pop for one requester cancel.
   always_comb begin
      occ_d = occ_q;
      inc   = 1'b0;
      dec   = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         inc = xfer && (gnt_q == IDW'(i));
         dec = pop && (fifo_rd_id == IDW'(i));
         if (inc && !dec) begin
            occ_d[i] = occ_q[i] + 1'b1;
         end else if (dec && !inc) begin
            occ_d[i] = occ_q[i] - 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      rr_ptr_d = rr_ptr_q;
      bcnt_d   = bcnt_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_found) begin
               gnt_d   = pick_idx;
               bcnt_d  = '0;
               state_d = ARB_GRANT;
            end
         end
         default: begin
            if (xfer) begin
               bcnt_d = bcnt_q + 1'b1;
               // occ_d already includes this beat, so hitting QUOTA here
               // means the grant just filled its share.
               if (req_last[gnt_q] || (bcnt_q == BCNT_LAST) ||
                   (occ_d[gnt_q] == QUOTA_C)) begin
                  state_d  = ARB_IDLE;
                  rr_ptr_d = IDW'((32'(gnt_q) + 1) % NREQ);
                  bcnt_d   = '0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ARB_IDLE;
         gnt_q    <= '0;
         rr_ptr_q <= '0;
         bcnt_q   <= '0;
         occ_q    <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         rr_ptr_q <= rr_ptr_d;
         bcnt_q   <= bcnt_d;
         occ_q    <= occ_d;
      end
   end

   assign occ  = occ_q;
   assign idle = (state_q == ARB_IDLE) && (occ_q == '0);

endmodule

// File: tb/tb_nv_nvdla_cdma_img_fifo_arb.sv
module tb_nv_nvdla_cdma_img_fifo_arb;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req_valid;
   logic [35:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        fifo_wr_req;
   logic [10:0] fifo_wr_data;
   logic        fifo_wr_ready = 1'b1;
   logic        fifo_rd_req = 1'b0;
   logic        fifo_rd_ready = 1'b0;
   logic [1:0]  fifo_rd_id = 2'd0;
   logic [23:0] occ;
   logic        idle;

   logic        drv_valid [4];
   logic        drv_last  [4];
   logic [8:0]  drv_data  [4];

   assign req_valid = {drv_valid[3], drv_valid[2], drv_valid[1], drv_valid[0]};
   assign req_last  = {drv_last[3], drv_last[2], drv_last[1], drv_last[0]};
   assign req_data  = {drv_data[3], drv_data[2], drv_data[1], drv_data[0]};

   nv_nvdla_cdma_img_fifo_arb #(
      .NREQ      (4),
      .DW        (9),
      .QUOTA     (32),
      .MAX_BURST (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .fifo_wr_req   (fifo_wr_req),
      .fifo_wr_data  (fifo_wr_data),
      .fifo_wr_ready (fifo_wr_ready),
      .fifo_rd_req   (fifo_rd_req),
      .fifo_rd_ready (fifo_rd_ready),
      .fifo_rd_id    (fifo_rd_id),
      .occ           (occ),
      .idle          (idle)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int seed    = 0;

   int nbeats  [4];
   int sent    [4];
   bit last_en [4];

   logic [10:0] exp_q [$];
   int          log_id [$];
   int          log_cyc [$];

   function automatic logic [5:0] get_occ(input int i);
      return 6'(occ >> (6 * i));
   endfunction

   task automatic present(input int i);
      logic [8:0] d;
      if (sent[i] < nbeats[i]) begin
         d = 9'(i * 71 + sent[i] * 29 + seed);
         drv_valid[i] = 1'b1;
         drv_data[i]  = d;
         drv_last[i]  = last_en[i] && (sent[i] == nbeats[i] - 1);
         exp_q.push_back({2'(i), d});
      end else begin
         drv_valid[i] = 1'b0;
         drv_last[i]  = 1'b0;
      end
   endtask

   task automatic start_stream(input int i, input int n, input bit le);
      nbeats[i]  = n;
      sent[i]    = 0;
      last_en[i] = le;
      present(i);
   endtask

   // One clock: observe at negedge, let the edge happen, then advance
   // every requester whose beat was accepted.
   task automatic step();
      logic [3:0]  acc;
      logic [3:0]  exp_acc;
      logic [10:0] w;
      int          found;
      int          bad;
      @(negedge clk);
      cyc++;
      acc     = req_valid & req_ready;
      exp_acc = 4'b0;
      bad     = 0;
      for (int i = 0; i < 4; i++) if (get_occ(i) > 6'd32) bad++;
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL occ_bound: occ=%h, required every count <= 32", occ);
      end
      if (fifo_wr_req && fifo_wr_ready) begin
         w       = fifo_wr_data;
         exp_acc = 4'b1 << w[10:9];
         found   = -1;
         foreach (exp_q[k]) if (found < 0 && exp_q[k][10:9] == w[10:9]) found = k;
         n_tests++;
         if (found < 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: wr_data=%h, required no write pending", w);
         end else begin
            if (w !== exp_q[found]) begin
               n_fail++;
               $display("FAIL sb_data: wr_data=%h, required %h", w, exp_q[found]);
            end
            exp_q.delete(found);
         end
         log_id.push_back(int'(w[10:9]));
         log_cyc.push_back(cyc);
      end
      n_tests++;
      if (acc !== exp_acc) begin
         n_fail++;
         $display("FAIL accept_vec: valid&ready=%b, required %b", acc, exp_acc);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (acc[i[1:0]]) begin
            sent[i]++;
            present(i);
         end
      end
   endtask

   task automatic clear_drives();
      for (int i = 0; i < 4; i++) begin
         drv_valid[i] = 1'b0;
         drv_last[i]  = 1'b0;
         drv_data[i]  = 9'd0;
         nbeats[i]    = 0;
         sent[i]      = 0;
         last_en[i]   = 1'b0;
      end
      fifo_wr_ready = 1'b1;
      fifo_rd_req   = 1'b0;
      fifo_rd_ready = 1'b0;
      fifo_rd_id    = 2'd0;
      exp_q.delete();
      log_id.delete();
      log_cyc.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_drives();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_drives();
      @(negedge clk);
      n_tests += 5;
      if (fifo_wr_req !== 1'b0) begin n_fail++; $display("FAIL rst_wr_req: got %b, required 0", fifo_wr_req); end
      if (req_ready !== 4'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b, required 0000", req_ready); end
      if (fifo_wr_data !== 11'd0) begin n_fail++; $display("FAIL rst_wr_data: got %h, required 000", fifo_wr_data); end
      if (occ !== 24'd0) begin n_fail++; $display("FAIL rst_occ: got %h, required 000000", occ); end
      if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b, required 1", idle); end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if (idle !== 1'b1 || fifo_wr_req !== 1'b0) begin
         n_fail++;
         $display("FAIL post_rst: idle=%b wr_req=%b, required 1 and 0", idle, fifo_wr_req);
      end
   endtask

   task automatic test_single();
      int start;
      do_reset();
      seed  = 5;
      start = cyc;
      start_stream(1, 3, 1'b1);
      repeat (6) step();
      n_tests++;
      if (log_id.size() != 3) begin
         n_fail++;
         $display("FAIL single_count: got %0d writes, required 3", log_id.size());
      end else begin
         n_tests++;
         if (log_cyc[0] != start + 2 || log_cyc[1] != start + 3 || log_cyc[2] != start + 4) begin
            n_fail++;
            $display("FAIL single_timing: cycles %0d,%0d,%0d, required %0d,%0d,%0d",
                     log_cyc[0], log_cyc[1], log_cyc[2], start + 2, start + 3, start + 4);
         end
      end
      n_tests += 2;
      if (get_occ(1) !== 6'd3) begin n_fail++; $display("FAIL single_occ: got %0d, required 3", get_occ(1)); end
      if (dut.rr_ptr_q !== 2'd2) begin n_fail++; $display("FAIL single_rr_ptr: got %0d, required 2", dut.rr_ptr_q); end
   endtask

   task automatic test_fairness();
      int start;
      int errs;
      do_reset();
      seed  = 17;
      start = cyc;
      for (int i = 0; i < 4; i++) start_stream(i, 1000, 1'b0);
      for (int s = 0; s < 100 && log_id.size() < 40; s++) step();
      n_tests++;
      if (log_id.size() < 40) begin
         n_fail++;
         $display("FAIL fair_timeout: got %0d writes, required 40", log_id.size());
      end else begin
         errs = 0;
         for (int k = 0; k < 40; k++) begin
            if (log_id[k] != (k / 8) % 4) errs++;
            if (k > 0 && (log_cyc[k] - log_cyc[k-1]) != ((k % 8 == 0) ? 2 : 1)) errs++;
         end
         if (log_cyc[0] != start + 2) errs++;
         n_tests++;
         if (errs != 0) begin
            n_fail++;
            $display("FAIL fair_order: %0d grant order/gap errors, required 0", errs);
         end
      end
   endtask

   task automatic test_quota();
      do_reset();
      seed = 33;
      start_stream(0, 40, 1'b0);
      repeat (60) step();
      n_tests += 4;
      if (log_id.size() != 32) begin n_fail++; $display("FAIL quota_count: got %0d writes, required 32", log_id.size()); end
      if (get_occ(0) !== 6'd32) begin n_fail++; $display("FAIL quota_occ: got %0d, required 32", get_occ(0)); end
      if (req_ready !== 4'b0) begin n_fail++; $display("FAIL quota_ready: got %b, required 0000", req_ready); end
      if (fifo_wr_req !== 1'b0) begin n_fail++; $display("FAIL quota_wr_req: got %b, required 0", fifo_wr_req); end
      fifo_rd_req   = 1'b1;
      fifo_rd_ready = 1'b1;
      fifo_rd_id    = 2'd0;
      step();
      fifo_rd_req   = 1'b0;
      fifo_rd_ready = 1'b0;
      n_tests++;
      if (get_occ(0) !== 6'd31) begin n_fail++; $display("FAIL quota_pop_occ: got %0d, required 31", get_occ(0)); end
      repeat (2) step();
      n_tests += 2;
      if (log_id.size() != 33) begin n_fail++; $display("FAIL quota_regrant: got %0d writes, required 33", log_id.size()); end
      if (get_occ(0) !== 6'd32) begin n_fail++; $display("FAIL quota_refill: got %0d, required 32", get_occ(0)); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      seed = 61;
      start_stream(2, 5, 1'b1);
      repeat (6) step();
      n_tests++;
      if (get_occ(2) !== 6'd5) begin n_fail++; $display("FAIL simul_pre_occ: got %0d, required 5", get_occ(2)); end
      start_stream(2, 3, 1'b1);
      step();
      fifo_rd_req   = 1'b1;
      fifo_rd_ready = 1'b1;
      fifo_rd_id    = 2'd2;
      step();
      fifo_rd_req   = 1'b0;
      fifo_rd_ready = 1'b0;
      n_tests += 2;
      if (log_id.size() != 6) begin n_fail++; $display("FAIL simul_xfer: got %0d writes, required 6", log_id.size()); end
      if (get_occ(2) !== 6'd5) begin n_fail++; $display("FAIL simul_occ: got %0d, required 5", get_occ(2)); end
      repeat (4) step();
      n_tests++;
      if (get_occ(2) !== 6'd7) begin n_fail++; $display("FAIL simul_post_occ: got %0d, required 7", get_occ(2)); end
   endtask

   task automatic test_backpressure();
      logic [10:0] held;
      int          errs;
      do_reset();
      seed = 99;
      fifo_wr_ready = 1'b0;
      start_stream(3, 5, 1'b1);
      held = exp_q[0];
      step();
      errs = 0;
      repeat (10) begin
         step();
         if (req_ready !== 4'b0) errs++;
         if (fifo_wr_req !== 1'b1) errs++;
         if (fifo_wr_data !== held) errs++;
         if (get_occ(3) !== 6'd0) errs++;
         if (dut.bcnt_q !== 3'd0) errs++;
      end
      n_tests++;
      if (errs != 0) begin
         n_fail++;
         $display("FAIL bp_stall: %0d unstable samples, wr_data=%h, required %h held", errs, fifo_wr_data, held);
      end
      fifo_wr_ready = 1'b1;
      repeat (7) step();
      n_tests += 2;
      if (log_id.size() != 5) begin n_fail++; $display("FAIL bp_resume: got %0d writes, required 5", log_id.size()); end
      if (get_occ(3) !== 6'd5) begin n_fail++; $display("FAIL bp_occ: got %0d, required 5", get_occ(3)); end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      seed = 123;
      start_stream(3, 3, 1'b1);
      repeat (5) step();
      start_stream(3, 20, 1'b0);
      repeat (5) step();
      n_tests += 2;
      if (dut.bcnt_q !== 3'd4) begin n_fail++; $display("FAIL mid_pre_bcnt: got %0d, required 4", dut.bcnt_q); end
      if (get_occ(3) !== 6'd7) begin n_fail++; $display("FAIL mid_pre_occ: got %0d, required 7", get_occ(3)); end
      reset = 1'b1;
      #1;
      n_tests += 5;
      if (fifo_wr_req !== 1'b0) begin n_fail++; $display("FAIL mid_wr_req: got %b, required 0", fifo_wr_req); end
      if (req_ready !== 4'b0) begin n_fail++; $display("FAIL mid_ready: got %b, required 0000", req_ready); end
      if (fifo_wr_data !== 11'd0) begin n_fail++; $display("FAIL mid_wr_data: got %h, required 000", fifo_wr_data); end
      if (occ !== 24'd0) begin n_fail++; $display("FAIL mid_occ: got %h, required 000000", occ); end
      if (idle !== 1'b1) begin n_fail++; $display("FAIL mid_idle: got %b, required 1", idle); end
      @(posedge clk);
      #1 reset = 1'b0;
      n_tests++;
      if (idle !== 1'b1 || dut.state_q !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_release: idle=%b state=%b, required 1 and IDLE(0)", idle, dut.state_q);
      end
      clear_drives();
   endtask

   initial begin
      clear_drives();
      test_reset();
      test_single();
      test_fairness();
      test_quota();
      test_simultaneous();
      test_backpressure();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/nv_nvdla_cdma_img_fifo_arb.md
# nv_nvdla_cdma_img_fifo_arb

Round-robin write-port arbiter and occupancy governor for the CDMA image-path 128x11 FIFO. It shares the FIFO's single valid/ready write port between `NREQ` image sub-requesters: pixel-unpack lanes and the pad/fill generator. Each accepted beat is tagged with its requester ID in the upper FIFO bits. Per-requester occupancy is tracked by snooping FIFO pops, so no requester can hold more than `QUOTA` entries and starve the others.

## Interface
- `NREQ`, 4: number of requesters; the ID width is `IDW = 2`, fixed.
- `DW`, 9: payload width; `DW + IDW` must equal 11.
- `QUOTA`, 32: maximum FIFO entries any one requester may own; `NREQ*QUOTA` must be ≤ 128.
- `MAX_BURST`, 8: maximum beats per grant before re-arbitration.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester beat valid.
- `req_data`  in  NREQ*DW  per-requester payload; requester i occupies bits `[i*DW +: DW]`.
- `req_last`  in  NREQ  last beat of a requester's burst.
- `req_ready`  out  NREQ  beat accepted when `req_valid[i] && req_ready[i]`.
- `fifo_wr_req`  out  1  to the FIFO `wr_req`.
- `fifo_wr_data`  out  11  `{id[1:0], payload[8:0]}`.
- `fifo_wr_ready`  in  1  from the FIFO `wr_ready`.
- `fifo_rd_req`  in  1  snoop of the FIFO `rd_req`.
- `fifo_rd_ready`  in  1  snoop of the consumer `rd_ready`.
- `fifo_rd_id`  in  2  snoop of `rd_data[10:9]`.
- `occ`  out  NREQ*6  per-requester occupancy counts (6 bits each, holding 0..QUOTA).
- `idle`  out  1  state is IDLE and all `occ` counts are 0.

## Operation
- FSM states are IDLE and GRANT. The state, grant index `gnt[1:0]`, round-robin pointer `rr_ptr[1:0]` and burst counter `bcnt[2:0]` are all registered.
- Eligibility: `elig[i] = req_valid[i] && (occ[i] < QUOTA)`.
- IDLE:
  - If any requester is eligible, pick the first eligible index scanning `rr_ptr`, `rr_ptr+1`, … mod NREQ.
  - Load `gnt`, clear `bcnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT outputs are combinational from `gnt`:
  - `fifo_wr_req = elig[gnt]`.
  - `fifo_wr_data = {gnt, req_data[gnt]}`.
  - `req_ready[gnt] = fifo_wr_ready && (occ[gnt] < QUOTA)`.
  - All other `req_ready` bits are 0.
- Transfer: `xfer = fifo_wr_req && fifo_wr_ready`. On each transfer, `bcnt` increments.
- GRANT exits to IDLE, with `rr_ptr <= gnt+1` mod NREQ, on any of:
  - a transfer with `req_last[gnt]`;
  - a transfer with `bcnt == MAX_BURST-1`;
  - `occ[gnt]` reaching QUOTA on that same transfer.
- If `req_valid[gnt]` deasserts, GRANT is held; there is no timeout.
- Occupancy accounting:
  - `pop = fifo_rd_req && fifo_rd_ready` with `id = fifo_rd_id`.
  - `occ[i]` increments on a transfer with `gnt == i` and decrements on a pop with `id == i`.
  - A transfer and pop to the same i in the same cycle leaves `occ[i]` unchanged.
  - Counts saturate-free; bench assertions flag a decrement at 0 and an increment at QUOTA.
- Arithmetic: `rr_ptr` and `gnt` wrap mod NREQ. `bcnt` is 3 bits and never exceeds `MAX_BURST-1`.

## Timing
- Reset values: state IDLE, `gnt` 0, `rr_ptr` 0, `bcnt` 0, `occ` all 0, `fifo_wr_req` 0, `req_ready` all 0, `fifo_wr_data` 0, `idle` 1.
- Arbitration latency is one cycle: a `req_valid` seen in IDLE at cycle N allows the first transfer at cycle N+1.
- Each grant costs one IDLE bubble. Peak throughput is MAX_BURST/(MAX_BURST+1) of a beat per cycle.
- There is no combinational path from `fifo_wr_ready` to `fifo_wr_req`. There is a combinational path from `fifo_wr_ready` to `req_ready`, which is acceptable because the FIFO registers its `wr_req` input.
- `occ` updates in the cycle after the transfer or pop edge. Eligibility uses registered `occ`.
- Reset mid-burst: all state clears asynchronously, and no partial beat is left pending. FIFO contents are flushed by the same reset.

## Structure
- Shared package `nv_nvdla_cdma_img_pkg` holds:
  - the `IDW` constant and the FIFO width of 11;
  - FSM state encodings `ARB_IDLE=1'b0` and `ARB_GRANT=1'b1`;
  - the occupancy-count width of 6.
- One sub-module, `nv_nvdla_cdma_img_rr_pick`: a combinational NREQ-way round-robin first-one finder taking `elig` and `rr_ptr` and returning `{found, idx}`.

## Test plan
- Single requester: req1 sends 3 beats (last on the 3rd) with `fifo_wr_ready=1` → FIFO receives `0x200|d0`, `0x200|d1`, `0x200|d2` on consecutive cycles after a 1-cycle IDLE; `occ[1]=3`; `rr_ptr=2`.
- Fairness: all 4 requesters valid continuously, `MAX_BURST=8`, no last → grants go 0,1,2,3,0 in that order, each for exactly 8 beats with a 1-cycle bubble between grants.
- Quota: requester 0 streams 40 beats with no pops → exactly 32 are accepted, then `req_ready[0]=0` and `occ[0]=32`; one pop with id 0 → `occ[0]=31` and requester 0 is re-granted.
- Simultaneous transfer and pop, both for id 2, with `occ[2]=5` → `occ[2]` stays 5.
- Backpressure: `fifo_wr_ready=0` for 10 cycles in GRANT → `bcnt`, `occ` and FIFO data are stable and `req_ready=0`; when ready returns, the transfer proceeds.
- Reset asserted mid-burst (`bcnt=4`, `occ[3]=7`) → all outputs reach their reset values immediately; after release the FSM starts in IDLE with `idle=1`.
